mac_tx_user_fifo: RTL

Store-and-forward transmit FIFO between the user-side 32-bit TX interface and the MAC transmit byte engine. It accepts framed words on the `tx_mac_*` handshake, buffers whole frames, and releases each frame as a big-endian byte stream only after its final word is committed. Malformed and oversize frames are discarded in the FIFO, so the MAC never sees a partial frame.

---
 rtl/mac_tx_user_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_user_fifo.sv
// Store-and-forward TX FIFO: buffers whole 32-bit user frames, replays them as big-endian bytes.
// Latency: eop accepted at edge N -> tx_frame_avail after N, first byte valid after N+1.
// Backpressure: tx_mac_wa low when full (except while discarding); bytes hold while valid & !ready.
//
// Ports:
//   clk_user / reset (async, active-low)
//   tx_mac_{wa,wr,data,be,sop,eop}  user word write side
//   tx_byte_{valid,ready,data,sop,eop}  byte stream toward the MAC
//   tx_frame_avail  committed frame not yet fully read;  tx_drop  one-cycle discard pulse
module mac_tx_user_fifo #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk_user,
    input  logic        reset,
    output logic        tx_mac_wa,
    input  logic        tx_mac_wr,
    input  logic [31:0] tx_mac_data,
    input  logic [1:0]  tx_mac_be,
    input  logic        tx_mac_sop,
    input  logic        tx_mac_eop,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    output logic [7:0]  tx_byte_data,
    output logic        tx_byte_sop,
    output logic        tx_byte_eop,
    output logic        tx_frame_avail,
    output logic        tx_drop
);

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Entry layout: {sop, eop, be[1:0], data[31:0]}
    logic [35:0] mem [DEPTH];

    logic [AW:0]  wr_q, wr_d, commit_q, commit_d, rd_q;
    wstate_t      ws_q, ws_d;
    logic         drop_q, drop_d;
    logic [AW:0]  used, uncommitted;
    logic         accept, we, commit_evt;
    logic [AW-1:0] waddr;

    logic [35:0]  rword_q;
    logic         rvld_q;
    logic [1:0]   idx_q;
    logic         last_byte, byte_acc, rd_load, eop_acc;
    logic [AW:0]  frame_cnt_q, frame_cnt_d;

    assign used        = wr_q - rd_q;
    assign uncommitted = wr_q - commit_q;
    // Discard mode ignores fullness so the rest of an oversize frame can be swallowed.
    assign tx_mac_wa   = (used != FULL) || (ws_q == W_DROP);
    assign accept      = tx_mac_wa && tx_mac_wr;

    // ---------------- write side ----------------
    always_comb begin
        wr_d       = wr_q;
        commit_d   = commit_q;
        ws_d       = ws_q;
        drop_d     = 1'b0;
        we         = 1'b0;
        waddr      = wr_q[AW-1:0];
        commit_evt = 1'b0;
        case (ws_q)
            W_IDLE: begin
                if (accept) begin
                    if (tx_mac_sop) begin
                        we   = 1'b1;
                        wr_d = wr_q + 1'b1;
                        if (tx_mac_eop) begin
                            commit_d   = wr_q + 1'b1;
                            commit_evt = 1'b1;
                        end else begin
                            ws_d = W_FRAME;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            W_FRAME: begin
                if (uncommitted == FULL) begin
                    // Frame cannot fit: throw away what was stored and swallow the remainder.
                    wr_d   = commit_q;
                    drop_d = 1'b1;
                    ws_d   = W_DROP;
                end else if (accept) begin
                    we = 1'b1;
                    if (tx_mac_sop) begin
                        // Restart: the new sop word overwrites the abandoned frame's first slot.
                        drop_d = 1'b1;
                        waddr  = commit_q[AW-1:0];
                        wr_d   = commit_q + 1'b1;
                        if (tx_mac_eop) begin
                            commit_d   = commit_q + 1'b1;
                            commit_evt = 1'b1;
                            ws_d       = W_IDLE;
                        end
                    end else begin
                        wr_d = wr_q + 1'b1;
                        if (tx_mac_eop) begin
                            commit_d   = wr_q + 1'b1;
                            commit_evt = 1'b1;
                            ws_d       = W_IDLE;
                        end
                    end
                end
            end
            W_DROP: begin
                if (accept && tx_mac_eop) ws_d = W_IDLE;
            end
            default: ws_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            wr_q     <= '0;
            commit_q <= '0;
            ws_q     <= W_IDLE;
            drop_q   <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            commit_q <= commit_d;
            ws_q     <= ws_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_user) begin
        if (we) mem[waddr] <= {tx_mac_sop, tx_mac_eop, tx_mac_be, tx_mac_data};
    end

    assign tx_drop = drop_q;

    // ---------------- read side ----------------
    // be encodes the byte count modulo 4, so be-1 is the index of the final byte.
    assign last_byte = (idx_q == 2'd3) ||
                       (rword_q[34] && (rword_q[33:32] != 2'b00) && (idx_q == rword_q[33:32] - 2'd1));
    assign byte_acc  = rvld_q && tx_byte_ready;
    // Reload on the last-byte handshake keeps consecutive words and frames bubble-free.
    assign rd_load   = (!rvld_q || (byte_acc && last_byte)) && (rd_q != commit_q);
    assign eop_acc   = byte_acc && tx_byte_eop;

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            rword_q <= '0;
            rvld_q  <= 1'b0;
            idx_q   <= 2'd0;
        end else if (rd_load) begin
            rword_q <= mem[rd_q[AW-1:0]];
            rvld_q  <= 1'b1;
            idx_q   <= 2'd0;
            rd_q    <= rd_q + 1'b1;
        end else if (byte_acc) begin
            if (last_byte) rvld_q <= 1'b0;
            else           idx_q  <= idx_q + 2'd1;
        end
    end

    always_comb begin
        tx_byte_data = rword_q[31:24];
        case (idx_q)
            2'd0:    tx_byte_data = rword_q[31:24];
            2'd1:    tx_byte_data = rword_q[23:16];
            2'd2:    tx_byte_data = rword_q[15:8];
            default: tx_byte_data = rword_q[7:0];
        endcase
    end

    assign tx_byte_valid = rvld_q;
    assign tx_byte_sop   = rvld_q && rword_q[35] && (idx_q == 2'd0);
    assign tx_byte_eop   = rvld_q && rword_q[34] && last_byte;

    // ---------------- committed-frame count ----------------
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (commit_evt && !eop_acc)      frame_cnt_d = frame_cnt_q + 1'b1;
        else if (!commit_evt && eop_acc) frame_cnt_d = frame_cnt_q - 1'b1;
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign tx_frame_avail = (frame_cnt_q != '0);

endmodule
